// File: rtl/ps2_rx_fifo_pkg.sv
// ps2_rx_fifo_pkg: shared PS/2 frame constants and receiver state encoding
package ps2_rx_fifo_pkg;
  localparam int FRAME_BITS = 11;
  typedef enum logic [1:0] {IDLE, DPS, LOAD} state_t;
endpackage

// File: rtl/ps2_fifo.sv
// ps2_fifo: synchronous first-word-fall-through FIFO
//   clk, reset      clock, asynchronous active-high reset
//   wr_en, din      write request and data (dropped when full unless popping)
//   rd_en           pop the head (ignored while empty)
//   dout            head entry, 0 while empty
//   empty, full     0 entries / 2**AW entries
//   count           number of stored entries
module ps2_fifo #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [DW-1:0] din,
  input  logic          rd_en,
  output logic [DW-1:0] dout,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count
);
  logic [DW-1:0] mem [2**AW];
  logic [AW:0] wptr, rptr;
  logic do_rd, do_wr;
  // pointers carry one extra wrap bit so full and empty are distinguishable
  assign count = wptr - rptr;
  assign empty = count == '0;
  assign full  = count == {1'b1, {AW{1'b0}}};
  assign do_rd = rd_en & ~empty;
  assign do_wr = wr_en & (~full | do_rd);
  assign dout  = empty ? '0 : mem[rptr[AW-1:0]];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      wptr <= wptr + (AW+1)'(do_wr);
      rptr <= rptr + (AW+1)'(do_rd);
    end
  always_ff @(posedge clk)
    if (do_wr) mem[wptr[AW-1:0]] <= din;
endmodule

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: PS/2 device-to-host receiver with glitch filter, frame checks, timeout and output FIFO
//   clk, reset        clock, asynchronous active-high reset
//   ps2d, ps2c        raw PS/2 data and clock pins
//   rd_en             pop the FIFO head
//   dout, empty, full, count   FIFO head and occupancy
//   rx_done_tick      good frame stored
//   parity_err        frame dropped, even parity
//   frame_err         frame dropped, stop bit 0 or timeout
//   overrun           good frame dropped, FIFO full
module ps2_rx_fifo
  import ps2_rx_fifo_pkg::*;
#(
  parameter int FILTER_LEN = 8,
  parameter int FIFO_AW    = 4,
  parameter int TIMEOUT    = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ps2d,
  input  logic             ps2c,
  input  logic             rd_en,
  output logic [7:0]       dout,
  output logic             empty,
  output logic             full,
  output logic [FIFO_AW:0] count,
  output logic             rx_done_tick,
  output logic             parity_err,
  output logic             frame_err,
  output logic             overrun
);
  localparam int TW = $clog2(TIMEOUT);
  logic [FILTER_LEN-1:0] filt;
  logic f_ps2c, f_ps2c_next, fall;
  logic [1:0] d_sync;
  logic d;
  state_t state, state_next;
  logic [3:0] n, n_next;
  // the start bit falls off the bottom on the last shift, so only bits 10..1 are kept
  logic [FRAME_BITS-1:1] b, b_next;
  logic [TW-1:0] t, t_next;
  logic wr_en, good;
  assign d = d_sync[1];
  assign f_ps2c_next = &filt ? 1'b1 : ~|filt ? 1'b0 : f_ps2c;
  assign fall = f_ps2c & ~f_ps2c_next;
  assign good = b[10] & ^b[9:1];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      filt   <= '1;
      f_ps2c <= 1'b1;
      d_sync <= 2'b11;
      state  <= IDLE;
      n      <= '0;
      b      <= '0;
      t      <= '0;
    end else begin
      filt   <= {ps2c, filt[FILTER_LEN-1:1]};
      f_ps2c <= f_ps2c_next;
      d_sync <= {d_sync[0], ps2d};
      state  <= state_next;
      n      <= n_next;
      b      <= b_next;
      t      <= t_next;
    end
  always_comb begin
    state_next   = state;
    n_next       = n;
    b_next       = b;
    t_next       = '0;
    wr_en        = 1'b0;
    rx_done_tick = 1'b0;
    parity_err   = 1'b0;
    frame_err    = 1'b0;
    overrun      = 1'b0;
    case (state)
      IDLE:
        if (fall && !d) begin
          b_next     = {d, b[FRAME_BITS-1:2]};
          n_next     = 4'd9;
          state_next = DPS;
        end
      DPS:
        if (fall) begin
          b_next     = {d, b[FRAME_BITS-1:2]};
          state_next = n == '0 ? LOAD : DPS;
          n_next     = n == '0 ? n : n - 4'd1;
        end else if (t == TW'(TIMEOUT - 1)) begin
          frame_err  = 1'b1;
          state_next = IDLE;
          n_next     = '0;
        end else t_next = t + TW'(1);
      LOAD: begin
        state_next   = IDLE;
        frame_err    = ~b[10];
        parity_err   = b[10] & ~^b[9:1];
        overrun      = good & full & ~rd_en;
        wr_en        = good & ~(full & ~rd_en);
        rx_done_tick = wr_en;
      end
      default: state_next = IDLE;
    endcase
  end
  ps2_fifo #(.DW(8), .AW(FIFO_AW)) fifo (
    .clk(clk),
    .reset(reset),
    .wr_en(wr_en),
    .din(b[8:1]),
    .rd_en(rd_en),
    .dout(dout),
    .empty(empty),
    .full(full),
    .count(count)
  );
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb_ps2_rx_fifo: randomized and directed bench for ps2_rx_fifo against a queue-based frame model
module tb_ps2_rx_fifo;
  localparam int FL = 8, AW = 2, TO = 5000, DEPTH = 4;
  logic clk = 0, reset = 0, ps2d = 1, ps2c = 1, rd_en = 0;
  logic [7:0] dout;
  logic empty, full;
  logic [AW:0] count;
  logic rx_done_tick, parity_err, frame_err, overrun;
  ps2_rx_fifo #(.FILTER_LEN(FL), .FIFO_AW(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .ps2d(ps2d), .ps2c(ps2c), .rd_en(rd_en),
    .dout(dout), .empty(empty), .full(full), .count(count),
    .rx_done_tick(rx_done_tick), .parity_err(parity_err),
    .frame_err(frame_err), .overrun(overrun)
  );
  always #10 clk = ~clk;
  int n_checks = 0, n_fail = 0;
  logic [7:0] q[$];
  int cyc = 0, fall_cyc = 0, done_cyc = -1, ferr_cyc = -1;
  int got_done = 0, got_perr = 0, got_ferr = 0, got_ovr = 0;
  int exp_done = 0, exp_perr = 0, exp_ferr = 0, exp_ovr = 0;
  int h = 40;
  bit quiet = 0, post_pending = 0;
  logic post_empty;
  logic [7:0] post_dout;
  logic [AW:0] post_count;
  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, got, exp, cyc);
    end
  endtask
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    if (!reset) begin
      if (post_pending) begin
        post_empty = empty;
        post_dout = dout;
        post_count = count;
        post_pending = 0;
      end
      chk("tick_onehot", 32'($countones({rx_done_tick, parity_err, frame_err, overrun}) <= 1), 1);
      if (rx_done_tick) begin got_done++; done_cyc = cyc; post_pending = 1; end
      if (parity_err) got_perr++;
      if (frame_err) begin got_ferr++; ferr_cyc = cyc; end
      if (overrun) got_ovr++;
      if (quiet) begin
        chk("count", 32'(count), q.size());
        chk("empty", 32'(empty), 32'(q.size() == 0));
        chk("full", 32'(full), 32'(q.size() == DEPTH));
        if (q.size() > 0) chk("dout", 32'(dout), 32'(q[0]));
      end
    end
  task automatic step(int k);
    repeat (k) @(posedge clk);
    #1;
  endtask
  task automatic chk_ticks();
    chk("ticks", {got_done[7:0], got_perr[7:0], got_ferr[7:0], got_ovr[7:0]},
                 {exp_done[7:0], exp_perr[7:0], exp_ferr[7:0], exp_ovr[7:0]});
  endtask
  // one PS/2 bit: data settles while the clock is high, then the clock falls;
  // with rd set, rd_en is held for exactly the cycle after the fall tick (the LOAD cycle)
  task automatic bit_out(bit dv, bit rd);
    ps2d = dv;
    step(h);
    ps2c = 0;
    fall_cyc = cyc;
    if (rd) begin
      step(FL + 1);
      rd_en = 1;
      step(1);
      rd_en = 0;
      void'(q.pop_front());
      step(h - FL - 2);
    end else step(h);
    ps2c = 1;
  endtask
  task automatic frame(logic [7:0] data, bit bad_par, bit stop, bit rd);
    logic [10:0] bits;
    bits = {stop, ~^data ^ bad_par, data, 1'b0};
    quiet = 0;
    for (int i = 0; i < 11; i++) bit_out(bits[i], rd && i == 10);
    step(h);
    if (!stop) exp_ferr++;
    else if (bad_par) exp_perr++;
    else if (q.size() == DEPTH) exp_ovr++;
    else begin exp_done++; q.push_back(data); end
    quiet = 1;
    chk_ticks();
  endtask
  task automatic pop_chk(logic [7:0] e);
    chk("dout_lit", 32'(dout), 32'(e));
    rd_en = 1;
    step(1);
    rd_en = 0;
    void'(q.pop_front());
    step(2);
  endtask
  initial begin
    #5 reset = 1;
    step(3);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_dout", 32'(dout), 0);
    chk("rst_ticks", 32'({rx_done_tick, parity_err, frame_err, overrun}), 0);
    reset = 0;
    step(2);
    quiet = 1;
    // good frame, latency and first-word-fall-through
    frame(8'h1C, 0, 1, 0);
    chk("done_latency", done_cyc - fall_cyc, FL + 1);
    chk("post_empty", 32'(post_empty), 0);
    chk("post_dout", 32'(post_dout), 32'h1C);
    chk("post_count", 32'(post_count), 1);
    pop_chk(8'h1C);
    chk("empty_after_pop", 32'(empty), 1);
    // parity and stop errors
    frame(8'h1C, 1, 1, 0);
    chk("perr_lit", got_perr, 1);
    frame(8'hF0, 0, 0, 0);
    chk("ferr_lit", got_ferr, 1);
    // timeout after four bits
    quiet = 0;
    for (int i = 0; i < 4; i++) bit_out(i != 0, 0);
    for (int k = 0; got_ferr == exp_ferr && k < TO + 2000; k++) step(1);
    chk("timeout_cycles", ferr_cyc - fall_cyc, FL + TO);
    exp_ferr++;
    quiet = 1;
    chk_ticks();
    frame(8'h5A, 0, 1, 0);
    pop_chk(8'h5A);
    // fill, overrun, then overrun avoided by a read in the LOAD cycle
    for (int i = 1; i <= 4; i++) frame(8'(i), 0, 1, 0);
    chk("full_at_4", 32'(full), 1);
    frame(8'h05, 0, 1, 0);
    chk("ovr_lit", got_ovr, 1);
    for (int i = 1; i <= 4; i++) pop_chk(8'(i));
    for (int i = 1; i <= 4; i++) frame(8'(i), 0, 1, 0);
    frame(8'h05, 0, 1, 1);
    chk("no_ovr_lit", got_ovr, 1);
    for (int i = 2; i <= 5; i++) pop_chk(8'(i));
    // glitches and a start-less fall in IDLE
    repeat (4) begin
      ps2c = 0;
      step(3);
      ps2c = 1;
      step(10);
    end
    ps2d = 1;
    step(h);
    ps2c = 0;
    step(h);
    ps2c = 1;
    step(h);
    chk_ticks();
    // reset mid-frame with a stored entry
    frame(8'h33, 0, 1, 0);
    quiet = 0;
    for (int i = 0; i < 5; i++) bit_out(i == 1 || i == 4, 0);
    #3 reset = 1;
    #2;
    chk("mid_rst_empty", 32'(empty), 1);
    chk("mid_rst_full", 32'(full), 0);
    chk("mid_rst_count", 32'(count), 0);
    chk("mid_rst_dout", 32'(dout), 0);
    chk("mid_rst_ticks", 32'({rx_done_tick, parity_err, frame_err, overrun}), 0);
    step(3);
    reset = 0;
    q.delete();
    step(2);
    quiet = 1;
    frame(8'h29, 0, 1, 0);
    pop_chk(8'h29);
    // randomized frames and reads
    repeat (8) begin
      if (q.size() > 0 && $urandom_range(1) == 1) pop_chk(q[0]);
      h = $urandom_range(30, 50);
      frame(8'($urandom), $urandom_range(3) == 0, $urandom_range(7) != 0, 0);
    end
    while (q.size() > 0) pop_chk(q[0]);
    chk_ticks();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
